// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the diad pipeline controller: default geometry,
// stage indices used by the core when raising a flush, and a popcount helper.
package pipe_ctrl_pkg;

  localparam int PIPE_DEPTH    = 8;
  localparam int HBIT_PIPE_IDX = 2;
  localparam int SIZE_PIPE_CNT = 32;

  // Stage indices for the default 8-register diad pipe (IA first, WB last).
  typedef enum logic [2:0] {
    STG_IA = 3'd0,
    STG_ID = 3'd1,
    STG_RD = 3'd2,
    STG_EX = 3'd3,
    STG_M1 = 3'd4,
    STG_M2 = 3'd5,
    STG_WR = 3'd6,
    STG_WB = 3'd7
  } stage_e;

  // Number of set bits in a vector of up to 16 valid flags.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int k = 0; k < 16; k++) begin
      n = n + {4'd0, v[k]};
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the core (master) and the pipeline controller (slave).
interface pipe_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH = PIPE_DEPTH,
  parameter int IDX_W = HBIT_PIPE_IDX + 1,
  parameter int CNT_W = SIZE_PIPE_CNT
);

  logic               iw_issue;
  logic [DEPTH-1:0]   iw_stall_req;
  logic               iw_flush;
  logic [IDX_W-1:0]   iw_flush_stg;

  logic [DEPTH-1:0]   ow_valid;
  logic [DEPTH-1:0]   ow_adv;
  logic [DEPTH-1:0]   ow_bubble;
  logic               ow_issue_ack;
  logic               ow_retire;
  logic               ow_stall_any;
  logic [IDX_W:0]     ow_occ;
  logic [CNT_W-1:0]   ow_cyc_cnt;
  logic [CNT_W-1:0]   ow_ret_cnt;
  logic [CNT_W-1:0]   ow_stl_cnt;
  logic [CNT_W-1:0]   ow_fl_cnt;

  modport master (
    output iw_issue, iw_stall_req, iw_flush, iw_flush_stg,
    input  ow_valid, ow_adv, ow_bubble, ow_issue_ack, ow_retire, ow_stall_any, ow_occ,
    input  ow_cyc_cnt, ow_ret_cnt, ow_stl_cnt, ow_fl_cnt
  );

  modport slave (
    input  iw_issue, iw_stall_req, iw_flush, iw_flush_stg,
    output ow_valid, ow_adv, ow_bubble, ow_issue_ack, ow_retire, ow_stall_any, ow_occ,
    output ow_cyc_cnt, ow_ret_cnt, ow_stl_cnt, ow_fl_cnt
  );

endinterface

// File: rtl/pipe_ctrl_cnt.sv
// Saturating event counter: counts enabled cycles and sticks at all-ones.
module pipe_ctrl_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             iw_clk,
  input  logic             iw_rst,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // Count up on enable until the all-ones ceiling, then hold.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (en && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline occupancy/advance controller for the diad core.
// Tracks one valid bit per pipeline register (0 = IA output, DEPTH-1 = WB output),
// resolves stalls and flushes into per-register load enables and bubble inserts.
// SQUEEZE=1 lets empty registers absorb upstream work instead of freezing the
// whole upstream pipe.
// Optional feature macro: PIPE_CTRL_PERF_EN builds four saturating perf counters;
// without it the counter ports are tied to zero and no counter flops exist.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH   = PIPE_DEPTH,
  parameter int IDX_W   = HBIT_PIPE_IDX + 1,
  parameter int SQUEEZE = 0,
  parameter int CNT_W   = SIZE_PIPE_CNT
) (
  input  logic     iw_clk,
  input  logic     iw_rst,
  pipe_ctrl_if.slave pif
);

  localparam logic [IDX_W:0]   DEPTH_W  = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] req_s;
  logic [DEPTH-1:0] hold_s;
  logic [DEPTH-1:0] next_s;
  logic [IDX_W-1:0] fstg_s;

  // Stall requests on empty registers carry no meaning.
  assign req_s = pif.iw_stall_req & valid_r;

  // Walk from WB back to IA so each register sees whether its consumer holds.
  always_comb begin
    logic carry;
    hold_s = {DEPTH{1'b0}};
    carry  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (SQUEEZE != 0) begin
        hold_s[i] = valid_r[i] & (req_s[i] | carry);
      end else begin
        hold_s[i] = req_s[i] | carry;
      end
      carry = hold_s[i];
    end
  end

  // Out-of-range flush index means the oldest register.
  always_comb begin
    if ({1'b0, pif.iw_flush_stg} >= DEPTH_W) begin
      fstg_s = LAST_IDX;
    end else begin
      fstg_s = pif.iw_flush_stg;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    localparam logic [IDX_W-1:0] G_IDX = IDX_W'(g);
    logic in_s;
    logic nf_s;

    if (g == 0) begin : g_head
      assign in_s = pif.iw_issue & ~pif.iw_flush;
    end else begin : g_body
      assign in_s = valid_r[g-1] & ~hold_s[g-1];
    end

    assign nf_s = hold_s[g] ? valid_r[g] : in_s;

    // Younger registers are squashed; the flusher stays only if it cannot leave.
    assign next_s[g] = !pif.iw_flush       ? nf_s :
                       (fstg_s > G_IDX)    ? 1'b0 :
                       (fstg_s == G_IDX)   ? hold_s[g] :
                                             nf_s;
  end

  // Valid bits; reset empties the pipe immediately.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      valid_r <= {DEPTH{1'b0}};
    end else begin
      valid_r <= next_s;
    end
  end

  assign pif.ow_valid     = valid_r;
  assign pif.ow_adv       = ~hold_s;
  assign pif.ow_bubble    = ~hold_s & ~next_s;
  assign pif.ow_issue_ack = ~hold_s[0] & pif.iw_issue & ~pif.iw_flush;
  assign pif.ow_retire    = valid_r[DEPTH-1] & ~req_s[DEPTH-1];
  assign pif.ow_stall_any = |req_s;
  assign pif.ow_occ       = (IDX_W + 1)'(popcount16(16'(valid_r)));

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_cnt_s;
  logic [CNT_W-1:0] ret_cnt_s;
  logic [CNT_W-1:0] stl_cnt_s;
  logic [CNT_W-1:0] fl_cnt_s;

  pipe_ctrl_cnt #(.CNT_W(CNT_W)) u_cyc_cnt (
    .iw_clk (iw_clk), .iw_rst (iw_rst), .en (1'b1),             .cnt (cyc_cnt_s)
  );
  pipe_ctrl_cnt #(.CNT_W(CNT_W)) u_ret_cnt (
    .iw_clk (iw_clk), .iw_rst (iw_rst), .en (pif.ow_retire),    .cnt (ret_cnt_s)
  );
  pipe_ctrl_cnt #(.CNT_W(CNT_W)) u_stl_cnt (
    .iw_clk (iw_clk), .iw_rst (iw_rst), .en (pif.ow_stall_any), .cnt (stl_cnt_s)
  );
  pipe_ctrl_cnt #(.CNT_W(CNT_W)) u_fl_cnt (
    .iw_clk (iw_clk), .iw_rst (iw_rst), .en (pif.iw_flush),     .cnt (fl_cnt_s)
  );

  assign pif.ow_cyc_cnt = cyc_cnt_s;
  assign pif.ow_ret_cnt = ret_cnt_s;
  assign pif.ow_stl_cnt = stl_cnt_s;
  assign pif.ow_fl_cnt  = fl_cnt_s;
`else
  assign pif.ow_cyc_cnt = {CNT_W{1'b0}};
  assign pif.ow_ret_cnt = {CNT_W{1'b0}};
  assign pif.ow_stl_cnt = {CNT_W{1'b0}};
  assign pif.ow_fl_cnt  = {CNT_W{1'b0}};
`endif

endmodule
